wash_cycle_ctrl: RTL

//  Washing-machine program sequencer feeding the display/LED view stage. Takes debounced single-cycle

---
 rtl/wash_pkg.sv | 65 ++++++
 rtl/tick_divider.sv | 23 ++
 rtl/wash_cycle_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/wash_pkg.sv
// rtl/wash_pkg.sv - shared encodings, program tables and helpers for the wash sequencer
package wash_pkg;

   typedef enum logic [2:0] {
      ST_SHUTDOWN = 3'd0,
      ST_BEGIN    = 3'd1,
      ST_SET      = 3'd2,
      ST_RUN      = 3'd3,
      ST_ERROR    = 3'd4,
      ST_PAUSE    = 3'd5,
      ST_FINISH   = 3'd6
   } washStateT;

   typedef enum logic [2:0] {
      S_W_IN   = 3'd0,
      S_WASH   = 3'd1,
      S_R_OUT  = 3'd2,
      S_R_SPIN = 3'd3,
      S_R_IN   = 3'd4,
      S_RINSE  = 3'd5,
      S_D_OUT  = 3'd6,
      S_D_SPIN = 3'd7
   } stepT;

   localparam int BIT_SET   = 9;
   localparam int BIT_POWER = 8;
   localparam int BIT_WASH  = 6;
   localparam int BIT_RINSE = 2;
   localparam int NUM_PROGS = 6;

   localparam logic [5:0] MAX_FIELD  = 6'd54;
   localparam logic [5:0] CODE_EMPTY = 6'd55;
   localparam logic [5:0] CODE_FULL  = 6'd56;
   localparam logic [5:0] CODE_PAUSE = 6'd57;

   // Bit s of the mask is set when step s belongs to the program (program index 0..5).
   function automatic logic [7:0] progMask(input logic [2:0] prog);
      case (prog)
         3'd0:    progMask = 8'b1111_1111;
         3'd1:    progMask = 8'b0000_0011;
         3'd2:    progMask = 8'b0011_1111;
         3'd3:    progMask = 8'b1111_1100;
         3'd4:    progMask = 8'b0011_1100;
         3'd5:    progMask = 8'b1100_0000;
         default: progMask = 8'b0000_0000;
      endcase
   endfunction

   // Lowest-numbered step present in the mask; wIn when the mask is empty.
   function automatic stepT lowestBit(input logic [7:0] m);
      lowestBit = S_W_IN;
      for (int i = 7; i >= 0; i--)
         if (m[i]) lowestBit = stepT'(3'(i));
   endfunction

   // Data bit index that lights the LED of a given step.
   function automatic logic [3:0] stepBit(input stepT s);
      stepBit = 4'd7 - {1'b0, s};
   endfunction

   function automatic logic [5:0] satField(input logic [9:0] v);
      satField = (v > {4'b0, MAX_FIELD}) ? MAX_FIELD : v[5:0];
   endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running time-base divider, held at zero while disabled
module tick_divider #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic cp,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == CW'(TICK_DIV - 1));

   // Count 0..TICK_DIV-1 while enabled; a disabled divider restarts from zero.
   always_ff @(posedge cp) begin
      if (rst || !en || tick) cnt <= '0;
      else                    cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/wash_cycle_ctrl.sv
// rtl/wash_cycle_ctrl.sv - washing-machine program sequencer with registered display outputs
module wash_cycle_ctrl
   import wash_pkg::*;
#(
   parameter int TICK_DIV     = 50_000_000,
   parameter int BEGIN_TICKS  = 1,
   parameter int FINISH_TICKS = 3,
   parameter int T_W_IN       = 3,
   parameter int T_WASH       = 9,
   parameter int T_R_OUT      = 2,
   parameter int T_R_SPIN     = 3,
   parameter int T_R_IN       = 3,
   parameter int T_RINSE      = 6,
   parameter int T_D_OUT      = 2,
   parameter int T_D_SPIN     = 6
) (
   input  logic       cp,
   input  logic       rst,
   input  logic       powerBtn,
   input  logic       startBtn,
   input  logic       modeBtn,
   input  logic       lidOpen,
   output logic [2:0] state,
   output logic [9:0] data,
   output logic [5:0] inLeft,
   output logic [5:0] inMiddle,
   output logic [5:0] inRight
);

   localparam logic [5:0] DUR [8] = '{6'(T_W_IN), 6'(T_WASH), 6'(T_R_OUT), 6'(T_R_SPIN),
                                      6'(T_R_IN), 6'(T_RINSE), 6'(T_D_OUT), 6'(T_D_SPIN)};

   washStateT  curState, nextState;
   stepT       curStep, nextStep, firstStep, laterStep;
   logic [2:0] prog, nextProg;
   logic [5:0] curRight, nextRight, nextLeft;
   logic [7:0] phaseCnt, nextPhase;
   logic [7:0] mask, laterMask, nextMask, nextLater;
   logic [9:0] nextData;
   logic       tick, divEn, laterFound;

   function automatic logic [9:0] sumMask(input logic [7:0] m);
      sumMask = '0;
      for (int i = 0; i < 8; i++)
         if (m[i]) sumMask = sumMask + {4'b0, DUR[i]};
   endfunction

   assign divEn = (curState == ST_BEGIN) || (curState == ST_RUN) || (curState == ST_FINISH);
   assign state = curState;

   tick_divider #(.TICK_DIV(TICK_DIV)) uDiv (
      .cp  (cp),
      .rst (rst),
      .en  (divEn),
      .tick(tick)
   );

   // Next-state logic: power first, then lid error, then start/pause, then time base.
   always_comb begin
      nextState  = curState;
      nextStep   = curStep;
      nextProg   = prog;
      nextRight  = curRight;
      nextPhase  = phaseCnt;
      mask       = progMask(prog);
      laterMask  = mask & (8'hFF << ({1'b0, curStep} + 4'd1));
      laterFound = |laterMask;
      laterStep  = lowestBit(laterMask);
      firstStep  = lowestBit(mask);
      if (powerBtn && curState != ST_SHUTDOWN) begin
         nextState = ST_SHUTDOWN;
         nextStep  = S_W_IN;
         nextRight = '0;
         nextPhase = '0;
      end else begin
         case (curState)
            ST_SHUTDOWN: if (powerBtn) begin
               nextState = ST_BEGIN;
               nextPhase = '0;
            end
            ST_BEGIN: if (tick) begin
               if (phaseCnt == 8'(BEGIN_TICKS - 1)) begin
                  nextState = ST_SET;
                  nextPhase = '0;
               end else nextPhase = phaseCnt + 8'd1;
            end
            ST_SET: if (startBtn) begin
               nextState = ST_RUN;
               nextStep  = firstStep;
               nextRight = DUR[firstStep];
            end else if (modeBtn) begin
               nextProg = (prog == 3'(NUM_PROGS - 1)) ? 3'd0 : prog + 3'd1;
            end
            ST_RUN: begin
               if (lidOpen && (curStep == S_R_SPIN || curStep == S_D_SPIN)) nextState = ST_ERROR;
               else if (startBtn) nextState = ST_PAUSE;
               else if (tick) begin
                  if (curRight > 6'd1) nextRight = curRight - 6'd1;
                  else if (laterFound) begin
                     nextStep  = laterStep;
                     nextRight = DUR[laterStep];
                  end else begin
                     nextState = ST_FINISH;
                     nextRight = '0;
                     nextPhase = '0;
                  end
               end
            end
            ST_ERROR: if (startBtn && !lidOpen) nextState = ST_RUN;
            ST_PAUSE: if (startBtn) nextState = ST_RUN;
            ST_FINISH: if (tick) begin
               if (phaseCnt == 8'(FINISH_TICKS - 1)) begin
                  nextState = ST_SHUTDOWN;
                  nextPhase = '0;
               end else nextPhase = phaseCnt + 8'd1;
            end
            default: nextState = ST_SHUTDOWN;
         endcase
      end
   end

   // Display values derived from the upcoming state so that they register alongside it.
   always_comb begin
      nextData  = '0;
      nextLeft  = '0;
      nextMask  = progMask(nextProg);
      nextLater = nextMask & (8'hFF << ({1'b0, nextStep} + 4'd1));
      if (nextState != ST_SHUTDOWN) nextData[BIT_POWER] = 1'b1;
      if (nextState == ST_SET) begin
         nextData[BIT_SET] = 1'b1;
         nextData[7:0]     = {<<{nextMask}};
         nextLeft          = satField(sumMask(nextMask));
      end else if (nextState == ST_RUN || nextState == ST_PAUSE || nextState == ST_ERROR) begin
         nextData[stepBit(nextStep)] = 1'b1;
         if (nextStep <= S_WASH)       nextData[BIT_WASH]  = 1'b1;
         else if (nextStep <= S_RINSE) nextData[BIT_RINSE] = 1'b1;
         nextLeft = satField({4'b0, nextRight} + sumMask(nextLater));
      end
   end

   // State, counters and all display outputs are registered together.
   always_ff @(posedge cp) begin
      if (rst) begin
         curState <= ST_SHUTDOWN;
         curStep  <= S_W_IN;
         prog     <= '0;
         curRight <= '0;
         phaseCnt <= '0;
         data     <= '0;
         inLeft   <= '0;
         inMiddle <= 6'd1;
      end else begin
         curState <= nextState;
         curStep  <= nextStep;
         prog     <= nextProg;
         curRight <= nextRight;
         phaseCnt <= nextPhase;
         data     <= nextData;
         inLeft   <= nextLeft;
         inMiddle <= {3'b0, nextProg} + 6'd1;
      end
   end

   assign inRight = curRight;

endmodule
